// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: issues accumulator-based commands to a combinational 4-bit ALU and returns results over valid/ready
module alu_cmd_sequencer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_load,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_data,
  output logic [1:0] alu_s,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [3:0] alu_c,
  input  logic       alu_c0,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] acc,
  output logic       carry,
  output logic [7:0] op_count
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d, acc_q, acc_d, alu_b_q, alu_b_d;
  logic [1:0] alu_s_q, alu_s_d;
  logic       carry_q, carry_d, rsp_valid_q, rsp_valid_d;
  logic [7:0] op_count_q, op_count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      alu_b_q     <= '0;
      alu_s_q     <= '0;
      carry_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      alu_b_q     <= alu_b_d;
      alu_s_q     <= alu_s_d;
      carry_q     <= carry_d;
      rsp_valid_q <= rsp_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    alu_b_d     = alu_b_q;
    alu_s_d     = alu_s_q;
    carry_d     = carry_q;
    rsp_valid_d = rsp_valid_q;
    op_count_d  = op_count_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        if (cmd_load) begin
          acc_d       = cmd_data;
          carry_d     = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          alu_s_d = cmd_op;
          alu_b_d = cmd_data;
          cnt_d   = 4'(SETTLE - 1);
          state_d = WAIT;
        end
      end
      WAIT: if (cnt_q == 4'd0) begin
        acc_d       = alu_c;
        // and/or have no meaningful carry, so the flag is cleared
        carry_d     = ~alu_s_q[1] & alu_c0;
        op_count_d  = (op_count_q == 8'hff) ? op_count_q : op_count_q + 8'd1;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign alu_s     = alu_s_q;
  assign alu_a     = acc_q;
  assign alu_b     = alu_b_q;
  assign rsp_valid = rsp_valid_q;
  assign acc       = acc_q;
  assign carry     = carry_q;
  assign op_count  = op_count_q;
endmodule
